// File: rtl/screenchar_write_arbiter.sv
// screenchar_write_arbiter
// Owns the single write port of the 256 x 8 screen character memory.
// Two writers (0 = status fields, 1 = terminal printer) take the port in
// whole bursts under round-robin arbitration; an owner that stalls for
// TIMEOUT consecutive cycles is forcibly released.
//
// Optional clear engine: define SCREENCHAR_ARB_CLEAR_EN to compile in the
// full-screen clear (CLEAR state, pending flag, address counter). Without
// it clear_start is ignored and clear_busy is tied low.
//
// Handshake: a beat on requester n is accepted in every cycle where
// reqn & gntn are both high (reqn acts as valid, gntn as ready). The
// requester must hold reqn and its beat stable until granted; reqn low
// while granted is a stall, not a release. Only lastn on an accepted beat
// (or the stall timeout) ends ownership.
//
// dbg_state exposes the FSM encoding: 0 IDLE, 1 OWN0, 2 OWN1, 3 CLEAR.
module screenchar_write_arbiter #(
   parameter logic [7:0] CLEAR_CHAR = 8'h20,
   parameter int         TIMEOUT    = 16
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       req0,
   input  logic [7:0] idx0,
   input  logic [7:0] chr0,
   input  logic       last0,
   input  logic       req1,
   input  logic [7:0] idx1,
   input  logic [7:0] chr1,
   input  logic       last1,
   output logic       gnt0,
   output logic       gnt1,
   input  logic       clear_start,
   output logic       clear_busy,
   output logic       timeout_err,
   output logic [7:0] mem_wraddress,
   output logic [7:0] mem_data,
   output logic       mem_wren,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN0  = 2'd1,
      OWN1  = 2'd2,
      CLEAR = 2'd3
   } state_t;

   // Forced release happens on the stall cycle that would make the count
   // reach TIMEOUT, so compare against TIMEOUT-1.
   localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT - 1);

   state_t     state;
   logic       rr_ptr;     // 0: requester 0 wins a tie, 1: requester 1 wins
   logic [7:0] stall_cnt;  // consecutive granted cycles without a beat

`ifdef SCREENCHAR_ARB_CLEAR_EN
   logic       clear_pend;
   logic [7:0] clr_cnt;

   assign clear_busy = clear_pend | (state == CLEAR);
`else
   logic clear_unused;

   assign clear_busy   = 1'b0;
   assign clear_unused = clear_start ^ (|CLEAR_CHAR);
`endif

   assign dbg_state = state;

   // Arbitration FSM, stall timer, clear engine and registered write port.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         rr_ptr        <= 1'b0;
         stall_cnt     <= '0;
         gnt0          <= 1'b0;
         gnt1          <= 1'b0;
         timeout_err   <= 1'b0;
         mem_wren      <= 1'b0;
         mem_wraddress <= '0;
         mem_data      <= '0;
`ifdef SCREENCHAR_ARB_CLEAR_EN
         clear_pend    <= 1'b0;
         clr_cnt       <= '0;
`endif
      end else begin
         mem_wren    <= 1'b0;
         timeout_err <= 1'b0;
`ifdef SCREENCHAR_ARB_CLEAR_EN
         // A request while one is pending or running is dropped, not queued.
         if (clear_start && !clear_busy)
            clear_pend <= 1'b1;
`endif
         case (state)
            IDLE: begin
               stall_cnt <= '0;
`ifdef SCREENCHAR_ARB_CLEAR_EN
               if (clear_pend) begin
                  state      <= CLEAR;
                  clear_pend <= 1'b0;
                  clr_cnt    <= '0;
               end else
`endif
               if (req0 && (!req1 || !rr_ptr)) begin
                  state <= OWN0;
                  gnt0  <= 1'b1;
               end else if (req1) begin
                  state <= OWN1;
                  gnt1  <= 1'b1;
               end
            end

            OWN0: begin
               if (req0) begin
                  mem_wren      <= 1'b1;
                  mem_wraddress <= idx0;
                  mem_data      <= chr0;
                  stall_cnt     <= '0;
                  if (last0) begin
                     state  <= IDLE;
                     gnt0   <= 1'b0;
                     rr_ptr <= ~rr_ptr;
                  end
               end else if (stall_cnt == STALL_LIMIT) begin
                  state       <= IDLE;
                  gnt0        <= 1'b0;
                  timeout_err <= 1'b1;
                  rr_ptr      <= ~rr_ptr;
                  stall_cnt   <= '0;
               end else begin
                  stall_cnt <= stall_cnt + 8'd1;
               end
            end

            OWN1: begin
               if (req1) begin
                  mem_wren      <= 1'b1;
                  mem_wraddress <= idx1;
                  mem_data      <= chr1;
                  stall_cnt     <= '0;
                  if (last1) begin
                     state  <= IDLE;
                     gnt1   <= 1'b0;
                     rr_ptr <= ~rr_ptr;
                  end
               end else if (stall_cnt == STALL_LIMIT) begin
                  state       <= IDLE;
                  gnt1        <= 1'b0;
                  timeout_err <= 1'b1;
                  rr_ptr      <= ~rr_ptr;
                  stall_cnt   <= '0;
               end else begin
                  stall_cnt <= stall_cnt + 8'd1;
               end
            end

`ifdef SCREENCHAR_ARB_CLEAR_EN
            CLEAR: begin
               mem_wren      <= 1'b1;
               mem_wraddress <= clr_cnt;
               mem_data      <= CLEAR_CHAR;
               clr_cnt       <= clr_cnt + 8'd1;
               // The wrap from 255 back to 0 ends the sweep.
               if (clr_cnt == 8'hFF)
                  state <= IDLE;
            end
`endif

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_screenchar_write_arbiter.sv
// Directed testbench for screenchar_write_arbiter. Clear-engine scenarios
// are compiled when SCREENCHAR_ARB_CLEAR_EN is defined; otherwise the
// disabled-clear behaviour is checked instead.
module tb_screenchar_write_arbiter;

   // ---------------- clock / reset / signals ----------------
   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0, last0 = 1'b0, last1 = 1'b0;
   logic [7:0] idx0 = '0, idx1 = '0, chr0 = '0, chr1 = '0;
   logic       clear_start = 1'b0;
   logic       gnt0, gnt1, clear_busy, timeout_err, mem_wren;
   logic [7:0] mem_wraddress, mem_data;
   logic [1:0] dbg_state;

   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] exp_q[$];
   logic [15:0] mon_exp;

   always #5 clock = ~clock;

   screenchar_write_arbiter #(.CLEAR_CHAR(8'h20), .TIMEOUT(16)) dut (
      .clock(clock), .resetn(resetn),
      .req0(req0), .idx0(idx0), .chr0(chr0), .last0(last0),
      .req1(req1), .idx1(idx1), .chr1(chr1), .last1(last1),
      .gnt0(gnt0), .gnt1(gnt1),
      .clear_start(clear_start), .clear_busy(clear_busy),
      .timeout_err(timeout_err),
      .mem_wraddress(mem_wraddress), .mem_data(mem_data), .mem_wren(mem_wren),
      .dbg_state(dbg_state)
   );

   // ---------------- scoreboard: every memory write vs expected queue ----------------
   always @(negedge clock) begin
      if (resetn && mem_wren) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL write_unexpected: got addr=%0d data=%h, required no write", mem_wraddress, mem_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({mem_wraddress, mem_data} !== mon_exp) begin
               n_bad++;
               $display("FAIL write_value: got addr=%0d data=%h, required addr=%0d data=%h",
                        mem_wraddress, mem_data, mon_exp[15:8], mon_exp[7:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      resetn = 1'b0;
      req0 = 0; req1 = 0; last0 = 0; last1 = 0;
      idx0 = 0; idx1 = 0; chr0 = 0; chr1 = 0; clear_start = 0;
      exp_q.delete();
      step();
      step();
      resetn = 1'b1;
      step();
   endtask

   task automatic check_drained(input string name);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL %s_drained: %0d writes still outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      resetn = 1'b0;
      #3;
      n_cmp++; if ({gnt0, gnt1, clear_busy, timeout_err, mem_wren} !== 5'b0) begin n_bad++; $display("FAIL reset_flags: got %b, required 00000", {gnt0, gnt1, clear_busy, timeout_err, mem_wren}); end
      n_cmp++; if ({mem_wraddress, mem_data} !== 16'h0) begin n_bad++; $display("FAIL reset_bus: got %h, required 0000", {mem_wraddress, mem_data}); end
      n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d, required 0", dbg_state); end
      apply_reset();
   endtask

   task automatic test_single_burst();
      logic [7:0] idxs [3];
      logic [7:0] chrs [3];
      idxs = '{8'd63, 8'd62, 8'd61};
      chrs = '{8'h31, 8'h32, 8'h33};
      apply_reset();
      req0 = 1; idx0 = idxs[0]; chr0 = chrs[0]; last0 = 0;
      step();
      n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin n_bad++; $display("FAIL single_grant: got gnt0/1=%b, required 10", {gnt0, gnt1}); end
      n_cmp++; if (mem_wren !== 1'b0) begin n_bad++; $display("FAIL single_idle_nowrite: got wren=%b, required 0", mem_wren); end
      for (int i = 0; i < 3; i++) exp_q.push_back({idxs[i], chrs[i]});
      for (int i = 0; i < 3; i++) begin
         idx0 = idxs[i]; chr0 = chrs[i]; last0 = (i == 2);
         step();
         n_cmp++; if (gnt0 !== (i < 2)) begin n_bad++; $display("FAIL single_gnt_beat%0d: got %b, required %b", i, gnt0, (i < 2)); end
      end
      req0 = 0; last0 = 0;
      step();
      n_cmp++; if ({gnt0, dbg_state} !== 3'b000) begin n_bad++; $display("FAIL single_after: got gnt0=%b state=%0d, required 0/0", gnt0, dbg_state); end
      check_drained("single");
   endtask

   task automatic test_contention();
      apply_reset();
      req0 = 1; idx0 = 8'h10; chr0 = 8'h41; last0 = 1;
      req1 = 1; idx1 = 8'h20; chr1 = 8'h42; last1 = 1;
      step();
      n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin n_bad++; $display("FAIL cont_first: got gnt0/1=%b, required 10", {gnt0, gnt1}); end
      exp_q.push_back({8'h10, 8'h41});
      step();
      n_cmp++; if ({gnt0, gnt1, dbg_state} !== 4'b0000) begin n_bad++; $display("FAIL cont_release0: got %b, required 0000", {gnt0, gnt1, dbg_state}); end
      req0 = 0;
      step();
      n_cmp++; if ({gnt0, gnt1} !== 2'b01) begin n_bad++; $display("FAIL cont_second: got gnt0/1=%b, required 01", {gnt0, gnt1}); end
      exp_q.push_back({8'h20, 8'h42});
      step();
      // Both again: pointer has flipped twice, so requester 0 wins.
      req0 = 1; idx0 = 8'h11; chr0 = 8'h43; idx1 = 8'h21; chr1 = 8'h44;
      step();
      n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin n_bad++; $display("FAIL cont_third: got gnt0/1=%b, required 10", {gnt0, gnt1}); end
      exp_q.push_back({8'h11, 8'h43});
      step();
      req0 = 0;
      step();
      n_cmp++; if ({gnt0, gnt1} !== 2'b01) begin n_bad++; $display("FAIL cont_fourth: got gnt0/1=%b, required 01", {gnt0, gnt1}); end
      exp_q.push_back({8'h21, 8'h44});
      step();
      req1 = 0; last0 = 0; last1 = 0;
      step();
      check_drained("cont");
   endtask

   task automatic test_stall();
      apply_reset();
      req1 = 1; idx1 = 8'd5; chr1 = 8'h78; last1 = 0;
      step();
      n_cmp++; if (gnt1 !== 1'b1) begin n_bad++; $display("FAIL stall_grant: got gnt1=%b, required 1", gnt1); end
      exp_q.push_back({8'd5, 8'h78});
      step();
      req1 = 0;
      for (int i = 1; i <= 16; i++) begin
         step();
         n_cmp++; if ({gnt1, timeout_err} !== {(i < 16), (i == 16)}) begin n_bad++; $display("FAIL stall_cycle%0d: got gnt1/err=%b, required %b", i, {gnt1, timeout_err}, {(i < 16), (i == 16)}); end
      end
      step();
      n_cmp++; if ({gnt1, timeout_err, dbg_state} !== 4'b0000) begin n_bad++; $display("FAIL stall_after: got %b, required 0000", {gnt1, timeout_err, dbg_state}); end
      step();
      check_drained("stall");
   endtask

   task automatic test_back_to_back();
      apply_reset();
      req0 = 1; idx0 = 8'd200; chr0 = 8'h50; last0 = 0;
      step();
      exp_q.push_back({8'd200, 8'h50});
      exp_q.push_back({8'd201, 8'h51});
      step();
      idx0 = 8'd201; chr0 = 8'h51; last0 = 1;
      step();
      n_cmp++; if (gnt0 !== 1'b0) begin n_bad++; $display("FAIL b2b_gap: got gnt0=%b, required 0", gnt0); end
      idx0 = 8'd202; chr0 = 8'h52; last0 = 1;
      step();
      n_cmp++; if (gnt0 !== 1'b1) begin n_bad++; $display("FAIL b2b_regrant: got gnt0=%b, required 1", gnt0); end
      exp_q.push_back({8'd202, 8'h52});
      step();
      req0 = 0; last0 = 0;
      step();
      check_drained("b2b");
   endtask

   task automatic test_reset_mid_burst();
      apply_reset();
      req0 = 1; idx0 = 8'd7; chr0 = 8'h61; last0 = 0;
      step();
      exp_q.push_back({8'd7, 8'h61});
      step();
      resetn = 0;
      #1;
      n_cmp++; if ({gnt0, mem_wren, mem_wraddress, mem_data} !== 18'h0) begin n_bad++; $display("FAIL rstburst_outputs: got %h, required 0", {gnt0, mem_wren, mem_wraddress, mem_data}); end
      exp_q.delete();
      req0 = 0;
      step();
      resetn = 1;
      step(); step();
      n_cmp++; if ({dbg_state, gnt0, mem_wren} !== 4'b0) begin n_bad++; $display("FAIL rstburst_after: got %b, required 0000", {dbg_state, gnt0, mem_wren}); end
   endtask

`ifdef SCREENCHAR_ARB_CLEAR_EN
   task automatic test_clear_during_burst();
      apply_reset();
      req0 = 1; idx0 = 8'h80; chr0 = 8'h61; last0 = 0;
      step();
      for (int i = 0; i < 4; i++) exp_q.push_back({8'(8'h80 + i), 8'(8'h61 + i)});
      step();
      idx0 = 8'h81; chr0 = 8'h62; clear_start = 1;
      step();
      clear_start = 0;
      n_cmp++; if ({gnt0, clear_busy} !== 2'b11) begin n_bad++; $display("FAIL clr_pending: got gnt0/busy=%b, required 11", {gnt0, clear_busy}); end
      idx0 = 8'h82; chr0 = 8'h63;
      step();
      idx0 = 8'h83; chr0 = 8'h64; last0 = 1;
      step();
      req0 = 0; last0 = 0;
      n_cmp++; if ({gnt0, clear_busy} !== 2'b01) begin n_bad++; $display("FAIL clr_burst_done: got gnt0/busy=%b, required 01", {gnt0, clear_busy}); end
      for (int a = 0; a < 256; a++) exp_q.push_back({8'(a), 8'h20});
      step();
      n_cmp++; if ({dbg_state, mem_wren, clear_busy} !== 4'b1101) begin n_bad++; $display("FAIL clr_entry: got state/wren/busy=%b, required 1101", {dbg_state, mem_wren, clear_busy}); end
      for (int a = 0; a < 256; a++) begin
         if (a == 10) clear_start = 1;
         step();
         clear_start = 0;
         if (a < 255) begin
            n_cmp++; if (clear_busy !== 1'b1) begin n_bad++; $display("FAIL clr_busy_addr%0d: got %b, required 1", a, clear_busy); end
         end
      end
      step();
      n_cmp++; if ({clear_busy, dbg_state} !== 3'b000) begin n_bad++; $display("FAIL clr_done: got busy/state=%b, required 000", {clear_busy, dbg_state}); end
      for (int i = 0; i < 4; i++) step();
      check_drained("clr");
   endtask

   task automatic test_reset_mid_clear();
      apply_reset();
      clear_start = 1;
      step();
      clear_start = 0;
      step();
      for (int a = 0; a < 100; a++) exp_q.push_back({8'(a), 8'h20});
      for (int i = 0; i < 101; i++) step();
      n_cmp++; if ({mem_wren, mem_wraddress} !== {1'b1, 8'd100}) begin n_bad++; $display("FAIL rstclr_at100: got wren/addr=%b/%0d, required 1/100", mem_wren, mem_wraddress); end
      check_drained("rstclr_pre");
      resetn = 0;
      #1;
      n_cmp++; if ({clear_busy, mem_wren, mem_wraddress, mem_data, gnt0, gnt1, timeout_err} !== 21'h0) begin n_bad++; $display("FAIL rstclr_outputs: got busy=%b wren=%b addr=%0d data=%h, required all 0", clear_busy, mem_wren, mem_wraddress, mem_data); end
      step();
      resetn = 1;
      for (int i = 0; i < 5; i++) step();
      n_cmp++; if ({dbg_state, clear_busy} !== 3'b000) begin n_bad++; $display("FAIL rstclr_after: got state/busy=%b, required 000", {dbg_state, clear_busy}); end
   endtask
`else
   task automatic test_clear_disabled();
      apply_reset();
      clear_start = 1;
      step();
      clear_start = 0;
      n_cmp++; if (clear_busy !== 1'b0) begin n_bad++; $display("FAIL noclr_busy: got %b, required 0", clear_busy); end
      for (int i = 0; i < 260; i++) step();
      n_cmp++; if ({clear_busy, dbg_state} !== 3'b000) begin n_bad++; $display("FAIL noclr_after: got busy/state=%b, required 000", {clear_busy, dbg_state}); end
   endtask
`endif

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_single_burst();
      test_contention();
      test_stall();
      test_back_to_back();
      test_reset_mid_burst();
`ifdef SCREENCHAR_ARB_CLEAR_EN
      test_clear_during_burst();
      test_reset_mid_clear();
`else
      test_clear_disabled();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
